// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the memory-mapped GPIO input peripheral.
//   - register indices within the 16-byte window (word index = Address[3:2])
//   - port width and the MASK reset value
//   - a helper that zero-extends an 8-bit register to the 32-bit bus
package gpio_pkg;

  localparam int GPIO_WIDTH = 8;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_RISE = 2'd1,
    REG_FALL = 2'd2,
    REG_MASK = 2'd3
  } reg_idx_e;

  localparam logic [GPIO_WIDTH-1:0] MASK_RESET = 8'hFF;

  // Upper bus bits of every register read back as zero.
  function automatic logic [31:0] zext_reg(input logic [GPIO_WIDTH-1:0] v);
    return {{(32-GPIO_WIDTH){1'b0}}, v};
  endfunction

endpackage

// File: rtl/gpio_debouncer.sv
// gpio_debouncer: two-flop synchroniser plus a single shared debounce counter
// for the whole port.
//   clk, reset   : clock, asynchronous active-high reset
//   pins_i       : raw asynchronous pins
//   data_o       : debounced value (the DATA register)
//   commit_o     : high in the cycle whose closing edge loads a new DATA value
//   old_o, new_o : DATA before and after that edge, valid while commit_o is high
module gpio_debouncer
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] pins_i,
  output logic [GPIO_WIDTH-1:0] data_o,
  output logic                  commit_o,
  output logic [GPIO_WIDTH-1:0] old_o,
  output logic [GPIO_WIDTH-1:0] new_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [GPIO_WIDTH-1:0] sync1_q, sync1_d;
  logic [GPIO_WIDTH-1:0] sync2_q, sync2_d;
  logic [GPIO_WIDTH-1:0] prev_q, prev_d;
  logic [GPIO_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  commit;

  always_comb begin
    sync1_d = pins_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (sync2_q != prev_q) begin
      // Any movement on the synchronised value restarts the stability window.
      cnt_d = '0;
    end else if (sync2_q != data_q) begin
      if (cnt_q == CNT_LAST) begin
        data_d = sync2_q;
        cnt_d  = '0;
        commit = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o   = data_q;
  assign commit_o = commit;
  assign old_o    = data_q;
  assign new_o    = sync2_q;

endmodule

// File: rtl/gpio_in_responder.sv
// gpio_in_responder: 8-bit GPIO input peripheral on the data-memory bus.
// Debounces the pins and keeps sticky rising/falling edge flags.
//   clk, reset    : clock, asynchronous active-high reset
//   gpio_pins_i   : raw asynchronous pins
//   Mem_Write_i   : store strobe
//   Mem_Read_i    : load strobe
//   Address_i     : byte address; [31:4] selects the window, [3:2] the register
//   Write_Data_i  : store data
//   Read_Data_o   : combinational load data (0 unless hit and load)
//   Hit_o         : combinational window hit, independent of the strobes
// Registers: 0 DATA (RO), 1 RISE (W1C), 2 FALL (W1C), 3 MASK (RW).
module gpio_in_responder
  import gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h1001_0040,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] gpio_pins_i,
  input  logic                  Mem_Write_i,
  input  logic                  Mem_Read_i,
  input  logic [31:0]           Address_i,
  input  logic [31:0]           Write_Data_i,
  output logic [31:0]           Read_Data_o,
  output logic                  Hit_o
);

  logic [GPIO_WIDTH-1:0] data;
  logic                  commit;
  logic [GPIO_WIDTH-1:0] old_val, new_val;

  gpio_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .pins_i  (gpio_pins_i),
    .data_o  (data),
    .commit_o(commit),
    .old_o   (old_val),
    .new_o   (new_val)
  );

  logic [GPIO_WIDTH-1:0] rise_q, rise_d;
  logic [GPIO_WIDTH-1:0] fall_q, fall_d;
  logic [GPIO_WIDTH-1:0] mask_q, mask_d;

  logic                  hit;
  reg_idx_e              reg_idx;
  logic                  wr_rise, wr_fall, wr_mask;
  logic [GPIO_WIDTH-1:0] rise_set, fall_set, rise_clr, fall_clr;
  logic [GPIO_WIDTH-1:0] wr_byte;

  // Byte lanes and the upper data bits have no meaning here.
  logic unused_bits;
  assign unused_bits = ^{Address_i[1:0], Write_Data_i[31:GPIO_WIDTH]};

  assign hit     = (Address_i[31:4] == BASE_ADDR[31:4]);
  assign reg_idx = reg_idx_e'(Address_i[3:2]);
  assign wr_byte = Write_Data_i[GPIO_WIDTH-1:0];

  always_comb begin
    wr_rise  = hit && Mem_Write_i && (reg_idx == REG_RISE);
    wr_fall  = hit && Mem_Write_i && (reg_idx == REG_FALL);
    wr_mask  = hit && Mem_Write_i && (reg_idx == REG_MASK);

    // Edge flags use the MASK value in force before this edge, so a MASK
    // store only affects commits on later edges.
    rise_set = commit ? (~old_val &  new_val & mask_q) : '0;
    fall_set = commit ? ( old_val & ~new_val & mask_q) : '0;
    rise_clr = wr_rise ? wr_byte : '0;
    fall_clr = wr_fall ? wr_byte : '0;

    // Set is applied after clear so a coincident new edge is never lost.
    rise_d   = (rise_q & ~rise_clr) | rise_set;
    fall_d   = (fall_q & ~fall_clr) | fall_set;
    mask_d   = wr_mask ? wr_byte : mask_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
      mask_q <= MASK_RESET;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    Read_Data_o = '0;
    if (hit && Mem_Read_i) begin
      unique case (reg_idx)
        REG_DATA: Read_Data_o = zext_reg(data);
        REG_RISE: Read_Data_o = zext_reg(rise_q);
        REG_FALL: Read_Data_o = zext_reg(fall_q);
        REG_MASK: Read_Data_o = zext_reg(mask_q);
        default:  Read_Data_o = '0;
      endcase
    end
  end

  assign Hit_o = hit;

endmodule

// File: tb/tb_gpio_in_responder.sv
// Bench for gpio_in_responder with DEBOUNCE_CYCLES=4. Inputs change on the
// falling edge; a run-length model of the debounce rule and the register
// file is advanced on each rising edge and compared against the bus outputs
// late in every low phase. Directed reads pin the model with literals.
module tb_gpio_in_responder;

  localparam int          DEB  = 4;
  localparam logic [31:0] BASE = 32'h1001_0040;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pins  = 8'h00;
  logic        mw    = 1'b0;
  logic        mr    = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wd    = 32'h0;
  logic [31:0] rd;
  logic        hit;

  always #5 clk = ~clk;

  gpio_in_responder #(
    .BASE_ADDR(BASE),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gpio_pins_i (pins),
    .Mem_Write_i (mw),
    .Mem_Read_i  (mr),
    .Address_i   (addr),
    .Write_Data_i(wd),
    .Read_Data_o (rd),
    .Hit_o       (hit)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pins are seen by the port two edges late. DATA follows the synchronised
  // value once that value has been observed DEB+1 edges in a row.
  logic [7:0] m_data, m_rise, m_fall, m_mask;
  logic [7:0] m_ps1, m_ps2, m_last, m_s, m_set_r, m_set_f;
  int         m_run;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_mask = 8'hFF;
      m_ps1 = 8'h00; m_ps2 = 8'h00; m_last = 8'h00; m_run = 0;
    end else begin
      m_s = m_ps2;
      if (m_s == m_last) m_run = m_run + 1;
      else m_run = 1;
      m_last = m_s;
      m_set_r = 8'h00;
      m_set_f = 8'h00;
      if (m_s != m_data && m_run >= DEB + 1) begin
        m_set_r = ~m_data & m_s & m_mask;
        m_set_f = m_data & ~m_s & m_mask;
        m_data  = m_s;
      end
      if (mw && addr[31:4] == BASE[31:4]) begin
        case (addr[3:2])
          2'd1: m_rise = m_rise & ~wd[7:0];
          2'd2: m_fall = m_fall & ~wd[7:0];
          2'd3: m_mask = wd[7:0];
          default: ;
        endcase
      end
      m_rise = m_rise | m_set_r;
      m_fall = m_fall | m_set_f;
      m_ps2 = m_ps1;
      m_ps1 = pins;
    end
  end

  function automatic logic [31:0] model_read();
    if (!(mr && addr[31:4] == BASE[31:4])) return 32'h0;
    case (addr[3:2])
      2'd0:    return {24'h0, m_data};
      2'd1:    return {24'h0, m_rise};
      2'd2:    return {24'h0, m_fall};
      default: return {24'h0, m_mask};
    endcase
  endfunction

  // Compare process: once per cycle, after all directed activity settles.
  always @(negedge clk) begin
    #4;
    check("model_hit", {31'h0, hit}, {31'h0, addr[31:4] == BASE[31:4]});
    check("model_rd", rd, model_read());
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic rd_now(input int idx, input logic [31:0] exp, input string name);
    addr = BASE + 32'(idx) * 32'd4;
    mr   = 1'b1;
    mw   = 1'b0;
    #1;
    check(name, rd, exp);
  endtask

  task automatic store(input int idx, input logic [31:0] data);
    @(negedge clk);
    addr = BASE + 32'(idx) * 32'd4;
    wd   = data;
    mw   = 1'b1;
    mr   = 1'b0;
    @(negedge clk);
    mw   = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) step();
    reset = 1'b0;

    // Reset values.
    rd_now(0, 32'h0, "rst_data");
    rd_now(1, 32'h0, "rst_rise");
    rd_now(2, 32'h0, "rst_fall");
    step();
    rd_now(3, 32'h0000_00FF, "rst_mask");
    addr = BASE + 32'd16;
    #1;
    check("oob_hit", {31'h0, hit}, 32'h0);
    check("oob_rd", rd, 32'h0);

    // 00 -> A5: DATA changes exactly 7 edges after the pin change.
    step();
    pins = 8'hA5;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) rd_now(0, 32'h0, "lat6_data");
      if (k == 7) begin
        rd_now(0, 32'h0000_00A5, "lat7_data");
        rd_now(1, 32'h0000_00A5, "lat7_rise");
        rd_now(2, 32'h0, "lat7_fall");
      end
    end
    store(1, 32'hFF);
    rd_now(1, 32'h0, "rise_cleared");

    // Back to 00 sets FALL.
    step();
    pins = 8'h00;
    repeat (8) step();
    rd_now(2, 32'h0000_00A5, "fall_a5");
    store(2, 32'hFF);

    // 3-cycle glitch never reaches DATA.
    step();
    pins = 8'h01;
    repeat (3) step();
    pins = 8'h00;
    repeat (10) step();
    rd_now(0, 32'h0, "glitch_data");
    rd_now(1, 32'h0, "glitch_rise");
    rd_now(2, 32'h0, "glitch_fall");

    // Masked edges and W1C.
    store(3, 32'h0F);
    rd_now(3, 32'h0000_000F, "mask_0f");
    step();
    pins = 8'hFF;
    repeat (8) step();
    rd_now(0, 32'h0000_00FF, "mask_data_ff");
    rd_now(1, 32'h0000_000F, "mask_rise_0f");
    store(1, 32'h05);
    rd_now(1, 32'h0000_000A, "w1c_rise_0a");
    step();
    pins = 8'h00;
    repeat (8) step();
    rd_now(2, 32'h0000_000F, "mask_fall_0f");
    store(1, 32'hFF);
    store(2, 32'hFF);
    rd_now(1, 32'h0, "rise_clr2");

    // Clear and new rise on the same edge: the rise wins.
    step();
    pins = 8'h01;
    repeat (6) step();
    addr = BASE + 32'd4;
    wd   = 32'h01;
    mw   = 1'b1;
    mr   = 1'b0;
    step();
    mw   = 1'b0;
    rd_now(1, 32'h0000_0001, "set_wins_rise");
    rd_now(0, 32'h0000_0001, "set_wins_data");

    // DATA is read-only; MASK ignores upper bits; no load strobe reads 0.
    store(0, 32'h3C);
    rd_now(0, 32'h0000_0001, "data_ro");
    store(3, 32'hFFFF_FF33);
    rd_now(3, 32'h0000_0033, "mask_upper");
    mr = 1'b0;
    #1;
    check("noload_rd", rd, 32'h0);
    check("noload_hit", {31'h0, hit}, 32'h1);

    // Reset in the middle of a debounce count.
    step();
    pins = 8'h00;
    repeat (3) step();
    reset = 1'b1;
    rd_now(0, 32'h0, "midrst_data");
    rd_now(1, 32'h0, "midrst_rise");
    rd_now(3, 32'h0000_00FF, "midrst_mask");
    pins = 8'h80;
    step();
    rd_now(2, 32'h0, "midrst_fall");
    step();
    reset = 1'b0;

    // Pins high across reset release appear after the full latency.
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) rd_now(0, 32'h0, "rel6_data");
      if (k == 7) begin
        rd_now(0, 32'h0000_0080, "rel7_data");
        rd_now(1, 32'h0000_0080, "rel7_rise");
      end
    end

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_in_responder.md
# gpio_in_responder

Memory-mapped 8-bit GPIO input peripheral on the single-cycle core's data-memory bus: the read-side counterpart of the GPIO output port. It synchronises and debounces external pins and latches sticky rising/falling-edge flags. It answers CPU loads and stores in parallel with the data memory; the top level selects its `Read_Data_o` whenever `Hit_o` is high.

## Interface
- `BASE_ADDR`, default 32'h1001_0040: byte base of the 16-byte register window; must be 16-byte aligned.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised cycles required before the debounced value updates; legal range 1..65535.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `gpio_pins_i` in 8: raw asynchronous pins.
- `Mem_Write_i` in 1: store strobe from the control unit.
- `Mem_Read_i` in 1: load strobe.
- `Address_i` in 32: ALU-computed byte address.
- `Write_Data_i` in 32: store data (rs2).
- `Read_Data_o` out 32: load data, combinational.
- `Hit_o` out 1: address falls in the window, combinational, independent of the strobes.

## Operation
- Decode: hit = `Address_i[31:4] == BASE_ADDR[31:4]`. Register index = `Address_i[3:2]`. `Address_i[1:0]` is ignored; only whole-word access is supported.
- Registers:
  - 0 DATA (RO): debounced pin value in [7:0].
  - 1 RISE (W1C): sticky rising-edge flags.
  - 2 FALL (W1C): sticky falling-edge flags.
  - 3 MASK (RW): edge-enable mask in [7:0].
  - Bits [31:8] of every register read as 0 and ignore writes. Writes to DATA are ignored.
- `Read_Data_o` = selected register when hit && `Mem_Read_i`; otherwise 0.
- Synchroniser: two flops per bit give `sync`.
- Debounce: one shared counter for the whole port. Also keep `prev`, the previous `sync`.
  - When `sync != prev`, the counter clears to 0.
  - Otherwise, if `sync != DATA`, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while `sync == prev != DATA`: DATA <= `sync` and the counter clears.
  - When `sync == DATA`, the counter holds at 0.
- Edge capture, on the edge where DATA updates:
  - RISE |= `~DATA & sync & MASK`
  - FALL |= `DATA & ~sync & MASK`
- W1C: a store to RISE/FALL clears the bits where `Write_Data_i` is 1. If a set and a clear hit the same bit on the same edge, the set wins (the flag stays 1).
- A MASK change affects only edges committed after the write's clock edge.
- Reset values: sync flops, `prev`, DATA, RISE, FALL and counter all 0; MASK = 8'hFF. Outputs are combinational, so after reset `Hit_o` follows the address and `Read_Data_o` reads 0 for DATA/RISE/FALL and 8'hFF for MASK.
- Reset asserted mid-debounce discards the count; pins already high at reset release appear in DATA after the full latency, and they do set RISE if enabled.

## Timing
- Pin change to `sync`: 2 cycles.
- `sync` stable to DATA update: DEBOUNCE_CYCLES cycles after `prev` matches.
- Total pin-to-DATA latency: DEBOUNCE_CYCLES+3 edges. Glitches shorter than DEBOUNCE_CYCLES+1 synchronised cycles never reach DATA.
- Loads: zero-latency combinational, matching the single-cycle core.
- Stores: take effect at the same rising edge that retires the store instruction.
- RISE/FALL set on the same edge as DATA changes; readable by a load in the following cycle.

## Structure
- Shared package `gpio_pkg` holds:
  - register offsets (DATA=0, RISE=1, FALL=2, MASK=3)
  - GPIO_WIDTH=8
  - MASK reset value 8'hFF
- Natural sub-module: `gpio_debouncer`, containing the synchroniser, `prev`, the counter, DATA, and a one-cycle `commit` pulse carrying the old and new value.
- Edge flags, register file and decode live in the top.
- Counter width = $clog2(DEBOUNCE_CYCLES+1).

## Test plan
- Reset, then load DATA, RISE, FALL and MASK -> 0, 0, 0, 32'h0000_00FF; address BASE_ADDR+16 -> `Hit_o`=0 and `Read_Data_o`=0.
- With DEBOUNCE_CYCLES=4, pins 8'h00->8'hA5 held -> DATA reads 8'hA5 exactly 7 edges after the change; RISE=8'hA5 on the same edge; FALL=0.
- 3-cycle pulse to 8'h01 with DEBOUNCE_CYCLES=4 -> DATA, RISE and FALL stay 0.
- MASK=8'h0F, pins 8'h00->8'hFF -> RISE=8'h0F. Store 8'h05 to RISE -> RISE=8'h0A. Pins ->8'h00 -> FALL=8'h0F.
- Store 8'h01 to RISE on the same edge a new rise commits on bit 0 -> bit 0 reads 1.
- Store 8'h3C to DATA -> DATA unchanged. Reset asserted mid-count -> all registers return to reset values immediately.
